// File: rtl/mypackage.sv
// mypackage: shared oscillator constants and the wavetable fetch-state encoding.
package mypackage;
    localparam int PHASE_ACCUMULATOR_FRACTIONAL_BITS = 16;
    localparam int WAVETABLE_ADDR_BITS = 11;
    localparam int PHASE_ACCUMULATOR_BITS = WAVETABLE_ADDR_BITS + PHASE_ACCUMULATOR_FRACTIONAL_BITS;
    typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B, CAPTURE} fetch_state_e;
endpackage

// File: rtl/phase_accumulator.sv
// phase_accumulator: wrapping oscillator phase register with hard sync.
// On advance the next phase is (sync ? 0 : phase) + increment, modulo 2^ACC_BITS.
module phase_accumulator
    import mypackage::*;
#(
    parameter int ACC_BITS = PHASE_ACCUMULATOR_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                advance,
    input  logic                sync,
    input  logic [ACC_BITS-1:0] increment,
    output logic [ACC_BITS-1:0] phase_out
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) phase_out <= '0;
        else if (advance) phase_out <= (sync ? '0 : phase_out) + increment;
    end
endmodule

// File: rtl/wavetable_fetch.sv
// wavetable_fetch: per-strobe phase advance and two-sample ROM fetch feeding lerp.
// inb=table[idx], ina=table[idx+1], ratio=frac, all updated together with out_valid.
module wavetable_fetch
    import mypackage::*;
#(
    parameter int TABLE_ADDR_BITS = WAVETABLE_ADDR_BITS,
    parameter int SAMPLE_BITS     = 16,
    parameter int FRAC_BITS       = PHASE_ACCUMULATOR_FRACTIONAL_BITS
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 sample_strobe,
    input  logic                                 sync_in,
    input  logic [TABLE_ADDR_BITS+FRAC_BITS-1:0] increment,
    output logic [TABLE_ADDR_BITS-1:0]           rom_addr,
    input  logic [SAMPLE_BITS-1:0]               rom_data,
    output logic [SAMPLE_BITS-1:0]               ina,
    output logic [SAMPLE_BITS-1:0]               inb,
    output logic [FRAC_BITS-1:0]                 ratio,
    output logic                                 out_valid,
    output logic                                 overrun
);
    localparam int ACC = TABLE_ADDR_BITS + FRAC_BITS;
    fetch_state_e state, state_nxt;
    logic [ACC-1:0] phase, snap;
    logic [SAMPLE_BITS-1:0] shadow_b;
    logic accept;
    assign accept = sample_strobe && state == IDLE;
    phase_accumulator #(.ACC_BITS(ACC)) u_phase (
        .clk       (clk),
        .reset_n   (reset_n),
        .advance   (accept),
        .sync      (sync_in),
        .increment (increment),
        .phase_out (phase)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? FETCH_A : IDLE;
            FETCH_A: state_nxt = FETCH_B;
            FETCH_B: state_nxt = CAPTURE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            snap      <= '0;
            rom_addr  <= '0;
            shadow_b  <= '0;
            ina       <= '0;
            inb       <= '0;
            ratio     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= state == CAPTURE;
            if (sample_strobe && state != IDLE) overrun <= 1'b1;
            if (accept) begin
                snap     <= sync_in ? '0 : phase;
                rom_addr <= sync_in ? '0 : phase[ACC-1:FRAC_BITS];
            end
            // second address wraps naturally at the table end
            if (state == FETCH_A) rom_addr <= snap[ACC-1:FRAC_BITS] + TABLE_ADDR_BITS'(1);
            if (state == FETCH_B) shadow_b <= rom_data;
            if (state == CAPTURE) begin
                ina   <= rom_data;
                inb   <= shadow_b;
                ratio <= snap[FRAC_BITS-1:0];
            end
        end
    end
endmodule

// File: tb/tb_wavetable_fetch.sv
// tb_wavetable_fetch: directed and random strobes checked against a phase/table model.
module tb_wavetable_fetch;
    import mypackage::*;
    localparam int TAB = 4;
    localparam int F   = PHASE_ACCUMULATOR_FRACTIONAL_BITS;
    localparam int ACC = TAB + F;
    logic clk = 0, reset_n = 0, sample_strobe = 0, sync_in = 0;
    logic [ACC-1:0] increment = '0;
    logic [TAB-1:0] rom_addr;
    logic [15:0] rom_data = '0, ina, inb;
    logic [F-1:0] ratio;
    logic out_valid, overrun;
    int tests = 0, fails = 0;
    logic [ACC-1:0] ph = '0;
    logic ovr = 0;
    logic [15:0] e_ina = '0, e_inb = '0;
    logic [F-1:0] e_ratio = '0;

    wavetable_fetch #(.TABLE_ADDR_BITS(TAB), .SAMPLE_BITS(16), .FRAC_BITS(F)) dut (
        .clk(clk), .reset_n(reset_n), .sample_strobe(sample_strobe), .sync_in(sync_in),
        .increment(increment), .rom_addr(rom_addr), .rom_data(rom_data),
        .ina(ina), .inb(inb), .ratio(ratio), .out_valid(out_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= {rom_addr, 12'h000};

    function automatic logic [15:0] tbl(input int i);
        return 16'((i % 16) * 4096);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_ina"}, 32'(ina), 32'(e_ina));
        chk({tag, "_inb"}, 32'(inb), 32'(e_inb));
        chk({tag, "_ratio"}, 32'(ratio), 32'(e_ratio));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        sample_strobe = 0;
        ph = '0; ovr = 0; e_ina = '0; e_inb = '0; e_ratio = '0;
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk_outs("rst");
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_strobe = 0;
            increment = ACC'($urandom);
            sync_in = 1'($urandom);
        end
    endtask

    // one accepted strobe; extra in 1..3 injects a second strobe at edge N+extra
    task automatic fetch(input logic [ACC-1:0] inc, input logic sy, input int extra);
        logic [ACC-1:0] snap;
        int idx;
        snap = sy ? '0 : ph;
        idx = int'(snap >> F);
        ph = snap + inc;
        @(negedge clk);
        sample_strobe = 1; increment = inc; sync_in = sy;
        @(posedge clk); #1;
        chk("addr_first", 32'(rom_addr), 32'(idx));
        chk("valid_n0", 32'(out_valid), 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            sample_strobe = (k == extra);
            increment = ACC'($urandom);
            sync_in = 1'($urandom);
            if (k == extra) ovr = 1;
            @(posedge clk); #1;
            if (k == 1) chk("addr_second", 32'(rom_addr), 32'((idx + 1) % 16));
            chk("valid_pulse", 32'(out_valid), 32'(k == 3));
            if (k == 3) begin
                e_inb = tbl(idx); e_ina = tbl(idx + 1); e_ratio = snap[F-1:0];
                chk_outs("capture");
            end
            if (k == 4) chk_outs("hold");
        end
        @(negedge clk);
        sample_strobe = 0;
        chk("overrun", 32'(overrun), 32'(ovr));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", 32'(out_valid), 0);
        chk("init_overrun", 32'(overrun), 0);
        chk_outs("init");
        @(negedge clk);
        reset_n = 1;
        // whole-sample increments
        for (int i = 0; i < 3; i++) begin fetch(ACC'(1) << F, 0, 0); idle(3); end
        chk("inc_last_inb", 32'(inb), 32'h2000);
        // half-sample increments: ratio alternates 0 and MSB
        do_reset();
        for (int i = 0; i < 4; i++) fetch(ACC'(1) << (F - 1), 0, 0);
        chk("half_ratio", 32'(ratio), 32'(1 << (F - 1)));
        chk("half_ina", 32'(ina), 32'h2000);
        // table wrap with carried fraction
        do_reset();
        for (int i = 0; i < 15; i++) fetch(ACC'(1) << F, 0, 0);
        fetch((ACC'(1) << F) + ACC'(16'h4000), 0, 0);
        chk("wrap_inb", 32'(inb), 32'hF000);
        chk("wrap_ina", 32'(ina), 32'h0000);
        fetch(ACC'(1) << F, 0, 0);
        chk("wrap_carry_ratio", 32'(ratio), 32'h4000);
        // overrun: strobe 2 cycles after an accepted one
        do_reset();
        fetch(ACC'(1) << F, 0, 2);
        fetch(ACC'(1) << F, 0, 0);
        chk("ovr_phase_once_inb", 32'(inb), 32'h1000);
        fetch(ACC'(1) << F, 0, 3);
        fetch(ACC'(1) << F, 0, 0);
        chk("ovr_sticky", 32'(overrun), 1);
        // hard sync
        do_reset();
        for (int i = 0; i < 5; i++) fetch(ACC'(1) << F, 0, 0);
        fetch(ACC'(1) << F, 1, 0);
        chk("sync_inb", 32'(inb), 32'h0000);
        fetch(ACC'(1) << F, 0, 0);
        chk("sync_next_inb", 32'(inb), 32'h1000);
        // reset in FETCH_B
        do_reset();
        fetch(ACC'(3) << F, 0, 0);
        @(negedge clk);
        sample_strobe = 1; increment = ACC'(1) << F; sync_in = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample_strobe = 0;
        reset_n = 0;
        ph = '0; ovr = 0; e_ina = '0; e_inb = '0; e_ratio = '0;
        #1;
        chk_outs("abort");
        chk("abort_addr", 32'(rom_addr), 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_valid", 32'(out_valid), 0);
        end
        @(negedge clk);
        reset_n = 1;
        fetch(ACC'(1) << F, 0, 0);
        chk("abort_restart_inb", 32'(inb), 32'h0000);
        // random increments, syncs, overruns and gaps
        for (int i = 0; i < 40; i++) begin
            fetch(ACC'($urandom), ($urandom_range(7) == 0), ($urandom_range(5) == 0) ? int'($urandom_range(3, 1)) : 0);
            idle(int'($urandom_range(3)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
